// File: rtl/fnd_counter_pkg.sv
// Shared constants and helpers for the 4-digit decimal counter and its
// multiplexed common-anode 7-segment display.
package fnd_counter_pkg;

  localparam int unsigned TICK_DIV_DEFAULT = 10_000_000;
  localparam int unsigned SCAN_DIV_DEFAULT = 100_000;
  localparam int unsigned DIGIT_W          = 4;
  localparam int unsigned SEG_W            = 8;
  localparam int unsigned COM_W            = 4;
  localparam int unsigned SCAN_IDX_W       = 2;

  // Active-low segments, bit order {dp,g,f,e,d,c,b,a}; dp always off
  localparam logic [SEG_W-1:0] SEG_0     = 8'hC0;
  localparam logic [SEG_W-1:0] SEG_1     = 8'hF9;
  localparam logic [SEG_W-1:0] SEG_2     = 8'hA4;
  localparam logic [SEG_W-1:0] SEG_3     = 8'hB0;
  localparam logic [SEG_W-1:0] SEG_4     = 8'h99;
  localparam logic [SEG_W-1:0] SEG_5     = 8'h92;
  localparam logic [SEG_W-1:0] SEG_6     = 8'h82;
  localparam logic [SEG_W-1:0] SEG_7     = 8'hF8;
  localparam logic [SEG_W-1:0] SEG_8     = 8'h80;
  localparam logic [SEG_W-1:0] SEG_9     = 8'h90;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  // Active-low digit commons; bit0 = ones, bit3 = thousands
  localparam logic [COM_W-1:0] COM_D0 = 4'b1110;
  localparam logic [COM_W-1:0] COM_D1 = 4'b1101;
  localparam logic [COM_W-1:0] COM_D2 = 4'b1011;
  localparam logic [COM_W-1:0] COM_D3 = 4'b0111;

  typedef struct packed {
    logic [DIGIT_W-1:0] d3;
    logic [DIGIT_W-1:0] d2;
    logic [DIGIT_W-1:0] d1;
    logic [DIGIT_W-1:0] d0;
  } bcd4_t;

  function automatic logic [SEG_W-1:0] seg_decode(input logic [DIGIT_W-1:0] bcd);
    logic [SEG_W-1:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // One decade step; anything at or above 9 rolls to 0 so 10..15 can never persist
  function automatic logic [DIGIT_W-1:0] decade_next(input logic [DIGIT_W-1:0] d,
                                                     input logic inc);
    logic [DIGIT_W-1:0] nxt;
    nxt = d;
    if (inc) begin
      nxt = (d >= 4'd9) ? 4'd0 : d + 4'd1;
    end
    return nxt;
  endfunction

  function automatic logic decade_carry(input logic [DIGIT_W-1:0] d, input logic inc);
    return inc && (d >= 4'd9);
  endfunction

endpackage

// File: rtl/fnd_controller.sv
// Digit-scan engine: cycles through four BCD digits, driving the matching
// active-low common and the decoded segment pattern.
module fnd_controller
  import fnd_counter_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  bcd4_t            digits,
  output logic [SEG_W-1:0] fnd_data,
  output logic [COM_W-1:0] fnd_com
);

  localparam int unsigned     SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
  logic [SCAN_IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic                  scan_wrap;
  logic [DIGIT_W-1:0]    sel_digit;

  // Scan divider and digit index advance
  always_comb begin
    scan_wrap  = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
    scan_idx_d = scan_wrap ? scan_idx_q + SCAN_IDX_W'(1) : scan_idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
    end
  end

  // Outputs decode straight from registers so common and segments switch together
  always_comb begin
    sel_digit = digits.d0;
    fnd_com   = COM_D0;
    case (scan_idx_q)
      2'd0: begin sel_digit = digits.d0; fnd_com = COM_D0; end
      2'd1: begin sel_digit = digits.d1; fnd_com = COM_D1; end
      2'd2: begin sel_digit = digits.d2; fnd_com = COM_D2; end
      2'd3: begin sel_digit = digits.d3; fnd_com = COM_D3; end
      default: ;
    endcase
    fnd_data = seg_decode(sel_digit);
  end

endmodule

// File: rtl/fnd_counter_top.sv
// Free-running 0000..9999 decimal counter shown on a 4-digit multiplexed
// common-anode 7-segment display.
module fnd_counter_top
  import fnd_counter_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  output logic [SEG_W-1:0] fnd_data,
  output logic [COM_W-1:0] fnd_com
);

  localparam int unsigned       TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;
  bcd4_t             bcd_q, bcd_d;
  logic              carry1, carry2, carry3;

  // Tick divider: one-cycle pulse on the last count before wrap
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
  end

  // Cascaded decades; all carries resolve on the same edge as the tick
  always_comb begin
    carry1   = decade_carry(bcd_q.d0, tick);
    carry2   = decade_carry(bcd_q.d1, carry1);
    carry3   = decade_carry(bcd_q.d2, carry2);
    bcd_d.d0 = decade_next(bcd_q.d0, tick);
    bcd_d.d1 = decade_next(bcd_q.d1, carry1);
    bcd_d.d2 = decade_next(bcd_q.d2, carry2);
    bcd_d.d3 = decade_next(bcd_q.d3, carry3);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      bcd_q      <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      bcd_q      <= bcd_d;
    end
  end

  fnd_controller #(
    .SCAN_DIV (SCAN_DIV)
  ) u_fnd_controller (
    .clk      (clk),
    .rst_n    (reset),
    .digits   (bcd_q),
    .fnd_data (fnd_data),
    .fnd_com  (fnd_com)
  );

endmodule

// File: tb/tb_fnd_counter_top.sv
// Directed bench for fnd_counter_top: a slow-scan instance for reset, scan,
// count, carry and async reset, plus a fast instance that runs through 9999 -> 0000.
module tb_fnd_counter_top;

  localparam int unsigned TICK   = 10;
  localparam int unsigned SCAN   = 4;
  localparam int unsigned TICK_F = 2;
  localparam int unsigned SCAN_F = 2;
  localparam int          NDIR   = 16;

  logic       clk;
  logic       reset;
  logic       reset_f;
  logic [7:0] fnd_data, fnd_data_f;
  logic [3:0] fnd_com, fnd_com_f;

  int checks = 0;
  int errors = 0;

  // Directed points after release: edge count, required common, required segments
  int         dir_n   [NDIR] = '{0, 3, 4, 7, 8, 9, 10, 12, 16, 19, 99, 100, 1000, 1004, 1008, 576};
  logic [3:0] dir_com [NDIR] = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'hB, 4'h7,
                                 4'hE, 4'hE, 4'hE, 4'hD, 4'hB, 4'h7, 4'hE, 4'hE};
  logic [7:0] dir_seg [NDIR] = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0,
                                 8'hF9, 8'hF9, 8'h90, 8'hF9, 8'hF9, 8'hC0, 8'hC0, 8'hF8};

  fnd_counter_top #(.TICK_DIV(TICK), .SCAN_DIV(SCAN)) dut (
    .clk      (clk),
    .reset    (reset),
    .fnd_data (fnd_data),
    .fnd_com  (fnd_com)
  );

  fnd_counter_top #(.TICK_DIV(TICK_F), .SCAN_DIV(SCAN_F)) dut_fast (
    .clk      (clk),
    .reset    (reset_f),
    .fnd_data (fnd_data_f),
    .fnd_com  (fnd_com_f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_ref(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [3:0] com_ref(input int i);
    case (i)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic int digit_ref(input int value, input int pos);
    int v;
    v = value;
    for (int k = 0; k < pos; k++) v = v / 10;
    return v % 10;
  endfunction

  // Display expected n rising edges after reset release
  task automatic check_model(input string tag, input int n, input int tdiv, input int sdiv,
                             input logic [3:0] com, input logic [7:0] data);
    int value;
    int idx;
    value = (n / tdiv) % 10000;
    idx   = (n / sdiv) % 4;
    check({tag, "_com"}, 32'(com), 32'(com_ref(idx)));
    check({tag, "_seg"}, 32'(data), 32'(seg_ref(digit_ref(value, idx))));
    check({tag, "_onehot"}, 32'($countones(~com)), 32'd1);
  endtask

  task automatic check_directed(input string tag, input int n);
    for (int k = 0; k < NDIR; k++) begin
      if (dir_n[k] == n) begin
        check({tag, "_com"}, 32'(fnd_com), 32'(dir_com[k]));
        check({tag, "_seg"}, 32'(fnd_data), 32'(dir_seg[k]));
      end
    end
  endtask

  task automatic run_main();
    logic [3:0] seen;
    reset = 1'b0;
    #3;
    check("rst_com", 32'(fnd_com), 32'h0000000E);
    check("rst_seg", 32'(fnd_data), 32'h000000C0);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_com", 32'(fnd_com), 32'h0000000E);
    check("rst_hold_seg", 32'(fnd_data), 32'h000000C0);
    reset = 1'b1;
    for (int n = 0; n <= 1100; n++) begin
      if (n > 0) @(negedge clk);
      check_model("run", n, TICK, SCAN, fnd_com, fnd_data);
      if (n < 1100) check_directed("dir", n);
    end

    // Hold the counter at 9999 and watch every digit position
    force dut.bcd_q = 16'h9999;
    seen = 4'h0;
    for (int n = 0; n < 4 * SCAN; n++) begin
      @(negedge clk);
      check("at9999_seg", 32'(fnd_data), 32'h00000090);
      seen = seen | ~fnd_com;
    end
    check("at9999_all_digits", 32'(seen), 32'h0000000F);
    release dut.bcd_q;

    // Restart, run to 0057, then drop reset between clock edges
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n <= 576; n++) begin
      if (n > 0) @(negedge clk);
      check_model("rerun", n, TICK, SCAN, fnd_com, fnd_data);
      if (n == 576) check_directed("pre_rst", n);
    end
    @(posedge clk);
    #1;
    check("async_pre_seg", 32'(fnd_data), 32'h000000F8);
    #1;
    reset = 1'b0;
    #1;
    check("async_com", 32'(fnd_com), 32'h0000000E);
    check("async_seg", 32'(fnd_data), 32'h000000C0);
    @(negedge clk);
    check("async_hold_seg", 32'(fnd_data), 32'h000000C0);
    reset = 1'b1;
    for (int n = 0; n <= 30; n++) begin
      if (n > 0) @(negedge clk);
      check_model("restart", n, TICK, SCAN, fnd_com, fnd_data);
      if (n == 9 || n == 16) check_directed("restart_dir", n);
    end
  endtask

  task automatic run_fast();
    reset_f = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_f = 1'b1;
    for (int n = 0; n <= 20004; n++) begin
      if (n > 0) @(negedge clk);
      check_model("fast", n, TICK_F, SCAN_F, fnd_com_f, fnd_data_f);
      if (n == 19996) begin
        check("wrap_9998_com", 32'(fnd_com_f), 32'h0000000B);
        check("wrap_9998_seg", 32'(fnd_data_f), 32'h00000090);
      end
      if (n == 19998) begin
        check("wrap_9999_com", 32'(fnd_com_f), 32'h00000007);
        check("wrap_9999_seg", 32'(fnd_data_f), 32'h00000090);
      end
      if (n == 20000) begin
        check("wrap_0000_com", 32'(fnd_com_f), 32'h0000000E);
        check("wrap_0000_seg", 32'(fnd_data_f), 32'h000000C0);
      end
    end
  endtask

  initial begin
    repeat (40000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      run_main();
      run_fast();
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fnd_counter_top.md
Name: fnd_counter_top

Overview:
- Top-level demo block: free-running 4-digit decimal counter (0000–9999) shown on a 4-digit common-anode 7-segment (FND) display.
- Digits are time-multiplexed.
- Sits directly at the board pins: one clock, one reset, segment bus and digit-common bus out.

Parameters:
- TICK_DIV, 10_000_000, clocks per counter increment (0.1 s at 100 MHz); minimum 2.
- SCAN_DIV, 100_000, clocks per digit-scan step (1 kHz at 100 MHz); minimum 2.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- fnd_data  output  8  segment drive, active-low, bit order {dp,g,f,e,d,c,b,a}.
- fnd_com  output  4  digit-common select, active-low; bit0 = ones digit, bit3 = thousands digit.

Behaviour:
- Reset (reset=0, asynchronous, clears immediately): all BCD digits = 0, both divider counters = 0, scan index = 0.
  - Outputs during and right after reset: fnd_com=4'b1110, fnd_data=8'hC0.
- Tick divider: counts 0..TICK_DIV-1 and wraps.
  - 1-cycle tick pulse in the cycle where the count equals TICK_DIV-1.
  - First tick occurs on the TICK_DIV-th rising edge after reset deasserts.
- Value counter: four cascaded BCD decade digits d0 (ones) .. d3 (thousands).
  - On tick: d0 increments; a digit at 9 wraps to 0 and carries to the next digit on the same edge.
  - 9999 + tick → 0000, with no flag and no stall.
  - Digits never hold values 10–15.
- Scan divider: counts 0..SCAN_DIV-1 and wraps.
  - On the wrap edge, the 2-bit scan index advances 0→1→2→3→0.
  - Scan and tick dividers are independent; simultaneous events are both applied on the same edge.
- Digit select, decoded combinationally from the registered index: index 0→4'b1110, 1→4'b1101, 2→4'b1011, 3→4'b0111.
  - Exactly one digit is active at any time.
- Segment decode, combinational from the selected digit, dp always off (bit7=1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).
  - Any other value → FF (blank). This is unreachable but must be defined.
- Leading zeros are displayed, not blanked.
- fnd_com and fnd_data change in the same cycle, directly after the index or digit register edge. No extra output pipeline stage.
- Reset asserted mid-count returns everything to the reset state asynchronously. Counting resumes from 0000 with a full TICK_DIV interval.

Decomposition:
- Shared package holds:
  - the segment constant table SEG_0..SEG_9 and SEG_BLANK (8'hFF);
  - the digit-select constants COM_D0..COM_D3;
  - default TICK_DIV and SCAN_DIV values.
- One natural sub-module: fnd_controller. It takes four BCD digits and contains the scan divider, index, digit mux and segment decoder.
- Tick divider and BCD counter remain in fnd_counter_top.

Test Plan (bench overrides TICK_DIV=10, SCAN_DIV=4; 10 ns clock):
- Reset: hold reset=0 for 20 ns, release.
  - During reset and through the first 4 clocks after release: fnd_com=1110, fnd_data=C0.
- Scan order: after release, sample fnd_com every 4 clocks.
  - Required sequence: 1110, 1101, 1011, 0111, 1110.
  - Each value held exactly 4 cycles; never two zero bits at once.
- Count: after 10 rising edges post-release, d0=1.
  - While fnd_com=1110, fnd_data=F9; while any other digit is selected, fnd_data=C0.
- Carry: after 100 ticks the value is 0100.
  - When fnd_com=1011, fnd_data=F9; at the other three digit selects, fnd_data=C0.
- Wrap: run 10,000 ticks (or preload via force) to reach 9999.
  - At 9999 all digits show 90.
  - On the next tick all digits show C0.
- Async reset mid-operation: pull reset low between clock edges at value 0057.
  - fnd_data=C0 and fnd_com=1110 immediately, without waiting for a clock edge.
  - After release, counting restarts from 0000.
